// File: rtl/pwm_capture.sv
// PWM period / high-time capture: synchronizes in_pwm, measures rise-to-rise
// period and rise-to-fall high time in in_clk cycles, with timeout on lost input.
module pwm_capture #(
  parameter int unsigned n = 8
) (
  input  logic         in_clk,
  input  logic         in_res,
  input  logic         in_pwm,
  input  logic         in_enable,
  output logic [n-1:0] out_period,
  output logic [n-1:0] out_high,
  output logic         out_valid,
  output logic         out_timeout
);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  localparam logic [n-1:0] CNT_ONE = n'(1);

  state_t       state, state_nxt;
  logic         s1, s2, s3;
  logic         rise, fall;
  logic [n-1:0] period_cnt, period_nxt;
  logic [n-1:0] high_cnt, high_nxt;
  logic         high_done, high_done_nxt;
  logic [n-1:0] out_period_nxt, out_high_nxt;
  logic         valid_nxt, timeout_nxt;

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  always_ff @(posedge in_clk) begin
    if (in_res) begin
      state       <= IDLE;
      s1          <= 1'b0;
      s2          <= 1'b0;
      s3          <= 1'b0;
      period_cnt  <= '0;
      high_cnt    <= '0;
      high_done   <= 1'b0;
      out_period  <= '0;
      out_high    <= '0;
      out_valid   <= 1'b0;
      out_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      s1          <= in_pwm;
      s2          <= s1;
      s3          <= s2;
      period_cnt  <= period_nxt;
      high_cnt    <= high_nxt;
      high_done   <= high_done_nxt;
      out_period  <= out_period_nxt;
      out_high    <= out_high_nxt;
      out_valid   <= valid_nxt;
      out_timeout <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    period_nxt     = period_cnt;
    high_nxt       = high_cnt;
    high_done_nxt  = high_done;
    out_period_nxt = out_period;
    out_high_nxt   = out_high;
    valid_nxt      = 1'b0;
    timeout_nxt    = 1'b0;

    // Disable outranks both a rise and a timeout landing in the same cycle.
    if (!in_enable) begin
      state_nxt     = IDLE;
      period_nxt    = '0;
      high_nxt      = '0;
      high_done_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt     = ARM;
          period_nxt    = '0;
          high_nxt      = '0;
          high_done_nxt = 1'b0;
        end
        ARM: begin
          if (rise) begin
            state_nxt     = MEASURE;
            period_nxt    = CNT_ONE;
            high_nxt      = CNT_ONE;
            high_done_nxt = 1'b0;
          end
        end
        MEASURE: begin
          // A rise closes one measurement and opens the next on the same edge.
          if (rise) begin
            out_period_nxt = period_cnt;
            out_high_nxt   = high_cnt;
            valid_nxt      = 1'b1;
            period_nxt     = CNT_ONE;
            high_nxt       = CNT_ONE;
            high_done_nxt  = 1'b0;
          end else if (period_cnt == '1) begin
            state_nxt     = ARM;
            timeout_nxt   = 1'b1;
            period_nxt    = '0;
            high_nxt      = '0;
            high_done_nxt = 1'b0;
          end else begin
            period_nxt = period_cnt + CNT_ONE;
            if (!high_done && s2) begin
              high_nxt = high_cnt + CNT_ONE;
            end
            if (fall) begin
              high_done_nxt = 1'b1;
            end
          end
        end
        default: begin
          state_nxt     = IDLE;
          period_nxt    = '0;
          high_nxt      = '0;
          high_done_nxt = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 The module SHALL have parameter n, default 8, giving the width of both measurement outputs and of the internal counters.
REQ-002 The module SHALL have port in_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port in_res, input, 1 bit: reset, synchronous, active-high.
REQ-004 The module SHALL have port in_pwm, input, 1 bit: PWM waveform to measure, asynchronous to in_clk.
REQ-005 The module SHALL have port in_enable, input, 1 bit: 1 = measure, 0 = idle.
REQ-006 The module SHALL have port out_period, output, n bits: last measured period, in in_clk cycles (rise to rise).
REQ-007 The module SHALL have port out_high, output, n bits: last measured high time, in in_clk cycles (rise to fall).
REQ-008 The module SHALL have port out_valid, output, 1 bit: one-cycle pulse when out_period and out_high update.
REQ-009 The module SHALL have port out_timeout, output, 1 bit: one-cycle pulse when no rising edge arrives within 2^n-1 cycles.

Function
REQ-010 in_pwm SHALL pass through a two-flop synchronizer (s1, s2), plus a third register s3 holding the previous s2.
REQ-011 rise SHALL be s2 & ~s3, and fall SHALL be ~s2 & s3, both evaluated combinationally from registered values.
REQ-012 The FSM SHALL have states IDLE, ARM and MEASURE.
REQ-013 IDLE: in_enable=1 -> ARM; otherwise remain; counters held at 0.
REQ-014 ARM: wait for rise -> MEASURE with period_cnt=1, high_cnt=1, high_done=0; no output change.
REQ-015 MEASURE, no rise: period_cnt SHALL increment by 1.
REQ-016 MEASURE, no rise, high_done=0 and s2=1: high_cnt SHALL increment by 1.
REQ-017 MEASURE, fall: high_done SHALL be set to 1 and high_cnt SHALL freeze.
REQ-018 MEASURE, rise: on the same edge, out_period SHALL load period_cnt, out_high SHALL load high_cnt, and out_valid SHALL be 1 for the following cycle only.
REQ-019 MEASURE, rise: on the same edge, counters SHALL restart (period_cnt=1, high_cnt=1, high_done=0) and the state SHALL remain MEASURE, giving back-to-back measurements with no lost edge.
REQ-020 MEASURE, period_cnt = 2^n-1 with no rise: state -> ARM, out_timeout = 1 for one cycle, counters cleared, out_period and out_high retained; no wrap-around ever occurs.
REQ-021 high_cnt SHALL never exceed period_cnt (it counts the same cycles, gated by s2).
REQ-022 in_enable=0 in any state SHALL force IDLE on the next edge: counters cleared, out_valid=0, out_timeout=0, out_period and out_high retained.
REQ-023 in_enable=0 SHALL take priority over rise and over timeout occurring in the same cycle.
REQ-024 Latency: an in_pwm rise set up before edge E0 SHALL produce rise during the cycle after E1, and out_valid high during the cycle after E2.
REQ-025 A pulse on in_pwm shorter than one in_clk cycle MAY be missed; a rise and fall SHALL NOT both be reported from the same s2/s3 sample.
REQ-026 out_valid and out_timeout SHALL never be high in the same cycle.

Reset
REQ-027 When in_res=1 at a clock edge, state SHALL become IDLE, s1=s2=s3=0, all counters and high_done 0, out_period=0, out_high=0, out_valid=0, out_timeout=0.
REQ-028 in_res SHALL have priority over in_enable and all other events, including mid-measurement; no partial measurement SHALL be reported after reset.
REQ-029 After reset releases, the first rise seen in ARM SHALL only start a measurement; the first out_valid SHALL follow the second rise.

Verification
REQ-030 The bench SHALL cover: n=8, enable=1, in_pwm period 10 cycles, high 3 -> from the second rise onward, out_valid every 10 cycles with out_period=10, out_high=3.
REQ-031 The bench SHALL cover: duty step from 3/10 to 7/10 mid-stream -> one report 10/3, then 10/7, with no missed out_valid.
REQ-032 The bench SHALL cover: in_pwm held constantly 1 after one rise -> out_timeout pulse 255 cycles after MEASURE entry, out_valid never pulses, state ARM.
REQ-033 The bench SHALL cover: in_pwm period 300 cycles at n=8 -> repeated out_timeout pulses, no out_valid, no counter wrap.
REQ-034 The bench SHALL cover: in_enable dropped mid-period, then re-raised -> no out_valid from the partial period, previous outputs retained, first new report after two rises.
REQ-035 The bench SHALL cover: in_res pulsed during MEASURE -> all outputs 0 next cycle, and the next report requires two fresh rises.
